// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
// Holds the funct3 encodings, the lsu_func field positions, the FSM
// state encoding and the request legality/alignment helpers.
package lsu_pkg;

  // lsu_func = {is_store, funct3}
  localparam int FUNC_STORE_BIT = 3;
  localparam int FUNC_F3_MSB    = 2;

  // Load encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // Store encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAULT = 2'b11
  } lsu_state_e;

  // True when {is_store, funct3} names a supported operation.
  function automatic logic func_legal(input logic is_store, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (funct3)
        SB, SH, SW: ok = 1'b1;
        default:    ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        LB, LH, LW, LBU, LHU: ok = 1'b1;
        default:              ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // True when the low address bits suit the access size in funct3[1:0].
  function automatic logic ea_aligned(input logic [2:0] funct3, input logic [1:0] ea_lo);
    logic ok;
    case (funct3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = (ea_lo[0] == 1'b0);
      2'b10:   ok = (ea_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// lsu_lane_mux: combinational byte-lane steering.
// Ports:
//   ea_lo      - effective address bits [1:0]
//   funct3     - access size / signedness
//   wdata      - raw store data (rs2)
//   mem_rdata  - raw bus read word
//   be         - byte enables for the access
//   store_data - store data replicated across all lanes
//   load_data  - selected lane, sign- or zero-extended
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [1:0]  ea_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte enables and store-lane replication by access size.
  always_comb begin
    be         = 4'b0000;
    store_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << ea_lo;
        store_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = ea_lo[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
      end
      2'b10: begin
        be         = 4'b1111;
        store_data = wdata;
      end
      default: begin
        be         = 4'b0000;
        store_data = wdata;
      end
    endcase
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    byte_s    = 8'h00;
    half_s    = ea_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (ea_lo)
      2'b00:   byte_s = mem_rdata[7:0];
      2'b01:   byte_s = mem_rdata[15:8];
      2'b10:   byte_s = mem_rdata[23:16];
      2'b11:   byte_s = mem_rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    case (funct3)
      LB:      load_data = {{24{byte_s[7]}}, byte_s};
      LH:      load_data = {{16{half_s[15]}}, half_s};
      LBU:     load_data = {24'h000000, byte_s};
      LHU:     load_data = {16'h0000, half_s};
      LW:      load_data = mem_rdata;
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage.
// Computes base+offset, checks legality/alignment, runs one req/ack bus
// transfer with byte enables and returns extended load data.
// Ports:
//   clk, _reset            - clock, async active-low reset
//   start, lsu_func        - op request (sampled in IDLE) and {is_store, funct3}
//   base, offset, wdata    - rs1, immediate, rs2
//   busy, done, fault      - stall, success pulse, error pulse
//   rdata                  - last successful load result
//   mem_addr/be/wdata/we/req, mem_ack/rdata/err - data-memory bus
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        start,
  input  logic [3:0]  lsu_func,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  // Counter value at which the REQ cycle without ack is the last allowed one.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_e  state_r;
  lsu_state_e  state_nxt_s;
  logic [7:0]  tmo_cnt_r;
  logic [1:0]  ea_lo_r;
  logic [2:0]  funct3_r;
  logic        is_store_r;
  logic [31:0] rdata_r;
  logic [29:0] mem_addr_r;
  logic [3:0]  mem_be_r;
  logic [31:0] mem_wdata_r;
  logic        mem_we_r;
  logic        mem_req_r;

  logic [31:0] ea_s;
  logic [2:0]  funct3_s;
  logic        is_store_s;
  logic        req_ok_s;
  logic        accept_s;
  logic        ack_s;
  logic        tmo_hit_s;
  logic [1:0]  mux_ea_s;
  logic [2:0]  mux_f3_s;
  logic [3:0]  be_s;
  logic [31:0] store_data_s;
  logic [31:0] load_data_s;

  assign ea_s       = base + offset;
  assign funct3_s   = lsu_func[FUNC_F3_MSB:0];
  assign is_store_s = lsu_func[FUNC_STORE_BIT];
  assign req_ok_s   = func_legal(is_store_s, funct3_s) && ea_aligned(funct3_s, ea_s[1:0]);
  assign accept_s   = (state_r == ST_IDLE) && start;
  assign ack_s      = (state_r == ST_REQ) && mem_ack;
  assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);

  // One lane mux serves both directions: live request fields while IDLE
  // (byte enables / store data) and the captured fields during REQ (load data).
  assign mux_ea_s = (state_r == ST_IDLE) ? ea_s[1:0] : ea_lo_r;
  assign mux_f3_s = (state_r == ST_IDLE) ? funct3_s  : funct3_r;

  lsu_lane_mux u_lane_mux (
    .ea_lo      (mux_ea_s),
    .funct3     (mux_f3_s),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .be         (be_s),
    .store_data (store_data_s),
    .load_data  (load_data_s)
  );

  // Next-state decision for the access FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = req_ok_s ? ST_REQ : ST_FAULT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          state_nxt_s = mem_err ? ST_FAULT : ST_DONE;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      ST_FAULT: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, bus registers, timeout counter and load result.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_r     <= ST_IDLE;
      tmo_cnt_r   <= 8'd0;
      ea_lo_r     <= 2'b00;
      funct3_r    <= 3'b000;
      is_store_r  <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      mem_addr_r  <= 30'd0;
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_we_r    <= 1'b0;
      mem_req_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s && req_ok_s) begin
        mem_addr_r  <= ea_s[31:2];
        mem_be_r    <= be_s;
        mem_wdata_r <= store_data_s;
        mem_we_r    <= is_store_s;
        mem_req_r   <= 1'b1;
        ea_lo_r     <= ea_s[1:0];
        funct3_r    <= funct3_s;
        is_store_r  <= is_store_s;
        tmo_cnt_r   <= 8'd0;
      end else if (state_r == ST_REQ) begin
        if (ack_s || tmo_hit_s) begin
          mem_req_r <= 1'b0;
          mem_be_r  <= 4'b0000;
          mem_we_r  <= 1'b0;
        end else begin
          tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end
        if (ack_s && !mem_err && !is_store_r) begin
          rdata_r <= load_data_s;
        end else begin
          rdata_r <= rdata_r;
        end
      end else begin
        mem_req_r <= mem_req_r;
      end
    end
  end

  // busy covers the acceptance cycle combinationally so the PC stalls at once.
  assign busy      = (state_r == ST_REQ) || accept_s;
  assign done      = (state_r == ST_DONE);
  assign fault     = (state_r == ST_FAULT);
  assign rdata     = rdata_r;
  assign mem_addr  = mem_addr_r;
  assign mem_be    = mem_be_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign mem_req   = mem_req_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit plus hand-written
// sequences for timeout and asynchronous reset during a transfer.
module tb_load_store_unit;

  logic        clk;
  logic        _reset;
  logic        start;
  logic [3:0]  lsu_func;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int n_checks;
  int n_fail;

  load_store_unit #(.TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    ._reset    (_reset),
    .start     (start),
    .lsu_func  (lsu_func),
    .base      (base),
    .offset    (offset),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  func;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    logic        err;
    logic        pre_fault;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic        we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int busy_cnt;
    @(negedge clk);
    start    = 1'b1;
    lsu_func = v.func;
    base     = v.base;
    offset   = v.off;
    wdata    = v.wd;
    #1;
    chk("busy_accept", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    if (v.pre_fault) begin
      chk("pre_fault", 32'(fault), 32'd1);
      chk("pre_fault_req", 32'(mem_req), 32'd0);
      chk("pre_fault_done", 32'(done), 32'd0);
      chk("pre_fault_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("pre_fault_pulse", 32'(fault), 32'd0);
      chk("pre_fault_req2", 32'(mem_req), 32'd0);
    end else begin
      chk("req", 32'(mem_req), 32'd1);
      chk("addr", 32'(mem_addr), 32'(v.addr));
      chk("be", 32'(mem_be), 32'(v.be));
      chk("we", 32'(mem_we), 32'(v.we));
      chk("mwdata", mem_wdata, v.mwd);
      busy_cnt = 0;
      for (int i = 0; i < v.waits; i++) begin
        chk("wait_req", 32'(mem_req), 32'd1);
        chk("wait_done", 32'(done), 32'd0);
        if (busy) busy_cnt++;
        @(negedge clk);
      end
      if (busy) busy_cnt++;
      chk("busy_cycles", 32'(busy_cnt), 32'(v.waits + 1));
      mem_ack   = 1'b1;
      mem_rdata = v.rd;
      mem_err   = v.err;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_err = 1'b0;
      chk("done", 32'(done), 32'(!v.err));
      chk("fault", 32'(fault), 32'(v.err));
      chk("req_drop", 32'(mem_req), 32'd0);
      chk("busy_end", 32'(busy), 32'd0);
      chk("be_clear", 32'(mem_be), 32'd0);
      chk("we_clear", 32'(mem_we), 32'd0);
      chk("rdata", rdata, v.exp_rdata);
      @(negedge clk);
      chk("pulse_end", 32'({done, fault}), 32'd0);
    end
  endtask

  initial begin
    int n;
    n_checks  = 0;
    n_fail    = 0;
    _reset    = 1'b0;
    start     = 1'b0;
    lsu_func  = 4'b0000;
    base      = 32'h0;
    offset    = 32'h0;
    wdata     = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    mem_err   = 1'b0;

    //          func     base          off           wd            rd            w  err pre addr          be       mwd           we    exp_rdata
    vecs[0]  = '{4'b0010, 32'h00001000, 32'h00000004, 32'h00000000, 32'hDEADBEEF, 0, 1'b0, 1'b0, 30'h00000401, 4'b1111, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{4'b0000, 32'h00001000, 32'h00000003, 32'h00000000, 32'h80FF0000, 0, 1'b0, 1'b0, 30'h00000400, 4'b1000, 32'h00000000, 1'b0, 32'hFFFFFF80};
    vecs[2]  = '{4'b0100, 32'h00001000, 32'h00000003, 32'h00000000, 32'h80FF0000, 0, 1'b0, 1'b0, 30'h00000400, 4'b1000, 32'h00000000, 1'b0, 32'h00000080};
    vecs[3]  = '{4'b1001, 32'h00002000, 32'h00000002, 32'h1234ABCD, 32'h55555555, 3, 1'b0, 1'b0, 30'h00000800, 4'b1100, 32'hABCDABCD, 1'b1, 32'h00000080};
    vecs[4]  = '{4'b0001, 32'h00001000, 32'h00000002, 32'h00000000, 32'h80011234, 1, 1'b0, 1'b0, 30'h00000400, 4'b1100, 32'h00000000, 1'b0, 32'hFFFF8001};
    vecs[5]  = '{4'b0101, 32'h00003000, 32'hFFFFFFFE, 32'h00000000, 32'hFFFF7FFE, 0, 1'b0, 1'b0, 30'h00000BFF, 4'b1100, 32'h00000000, 1'b0, 32'h0000FFFF};
    vecs[6]  = '{4'b1000, 32'h00000010, 32'h00000001, 32'h000000A5, 32'h00000000, 2, 1'b0, 1'b0, 30'h00000004, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'h0000FFFF};
    vecs[7]  = '{4'b1010, 32'hFFFFFFFC, 32'h00000008, 32'hCAFEF00D, 32'h00000000, 0, 1'b0, 1'b0, 30'h00000001, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0000FFFF};
    vecs[8]  = '{4'b0010, 32'h00001000, 32'h00000002, 32'h00000000, 32'h00000000, 0, 1'b0, 1'b1, 30'h0,         4'b0000, 32'h00000000, 1'b0, 32'h0000FFFF};
    vecs[9]  = '{4'b1011, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 0, 1'b0, 1'b1, 30'h0,         4'b0000, 32'h00000000, 1'b0, 32'h0000FFFF};
    vecs[10] = '{4'b0001, 32'h00001000, 32'h00000001, 32'h00000000, 32'h00000000, 0, 1'b0, 1'b1, 30'h0,         4'b0000, 32'h00000000, 1'b0, 32'h0000FFFF};
    vecs[11] = '{4'b0011, 32'h00001000, 32'h00000000, 32'h00000000, 32'h00000000, 0, 1'b0, 1'b1, 30'h0,         4'b0000, 32'h00000000, 1'b0, 32'h0000FFFF};
    vecs[12] = '{4'b0010, 32'h00000040, 32'h00000000, 32'h00000000, 32'h12345678, 0, 1'b1, 1'b0, 30'h00000010, 4'b1111, 32'h00000000, 1'b0, 32'h0000FFFF};

    // Reset state
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    _reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i]);
    end

    // Timeout: ack never arrives, mem_req must stay up exactly 4 cycles.
    @(negedge clk);
    start    = 1'b1;
    lsu_func = 4'b0010;
    base     = 32'h00000100;
    offset   = 32'h0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", 32'(n), 32'd4);
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("tmo_pulse", 32'(fault), 32'd0);

    // Start held through DONE must not launch a second transfer.
    @(negedge clk);
    start    = 1'b1;
    lsu_func = 4'b0010;
    base     = 32'h00000200;
    offset   = 32'h0;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_done_req", 32'(mem_req), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("hold_idle_req", 32'(mem_req), 32'd0);
    chk("hold_rdata", rdata, 32'h0BADF00D);

    // Async reset in the middle of REQ.
    @(negedge clk);
    start    = 1'b1;
    lsu_func = 4'b0010;
    base     = 32'h00000300;
    offset   = 32'h0;
    @(negedge clk);
    start = 1'b0;
    chk("mid_req_up", 32'(mem_req), 32'd1);
    #2;
    _reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    _reset = 1'b1;
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
